// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, manager FSM states, counter width.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } mgr_state_t;

    localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/axi4_if.sv
// AXI4-Lite channel bundle (AW, W, B, AR, R); no prot, no strobes.
interface axi4_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;

    modport manager (
        output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport subordinate (
        input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_mgr.sv
// AXI4-Lite manager: one outstanding single-beat command turned into an
// AW/W/B or AR/R transaction, with a registered response and an error count.
module axi4_lite_mgr
    import axi4_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ERR_CNT_W-1:0]  err_count,
    axi4_if.manager               m_axi
);

    // Byte-lane bits below the bus width are dropped from every address.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

    mgr_state_t            state, state_nxt;
    logic                  aw_done, w_done;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rsp_write_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [1:0]            rsp_resp_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q;

    logic awvalid_c, wvalid_c;
    logic aw_hs, w_hs, b_cap, r_cap;
    logic [1:0] cap_resp;

    assign aw_hs    = awvalid_c && m_axi.awready;
    assign w_hs     = wvalid_c && m_axi.wready;
    assign b_cap    = (state == WR_RESP) && m_axi.bvalid;
    assign r_cap    = (state == RD_DATA) && m_axi.rvalid;
    assign cap_resp = (state == WR_RESP) ? m_axi.bresp : m_axi.rresp;

    // State register plus per-channel done flags; each flag drops its valid
    // the cycle after its own handshake, so AW and W retire independently.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            aw_done <= (state_nxt == WR_REQ) && (aw_done || aw_hs);
            w_done  <= (state_nxt == WR_REQ) && (w_done || w_hs);
        end
    end

    // Next-state: wait on each channel in turn; no timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = cmd_write ? WR_REQ : RD_REQ;
            WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
            WR_RESP: if (m_axi.bvalid) state_nxt = RSP;
            RD_REQ:  if (m_axi.arready) state_nxt = RD_DATA;
            RD_DATA: if (m_axi.rvalid) state_nxt = RSP;
            RSP:     if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state and registered flags only, never from a ready.
    always_comb begin
        cmd_ready     = (state == IDLE);
        awvalid_c     = (state == WR_REQ) && !aw_done;
        wvalid_c      = (state == WR_REQ) && !w_done;
        m_axi.awvalid = awvalid_c;
        m_axi.wvalid  = wvalid_c;
        m_axi.bready  = (state == WR_RESP);
        m_axi.arvalid = (state == RD_REQ);
        m_axi.rready  = (state == RD_DATA);
        m_axi.awaddr  = addr_q;
        m_axi.araddr  = addr_q;
        m_axi.wdata   = wdata_q;
        rsp_valid     = (state == RSP);
        rsp_write     = rsp_write_q;
        rsp_rdata     = rsp_rdata_q;
        rsp_resp      = rsp_resp_q;
        err_count     = err_cnt_q;
    end

    // Command latch, response capture and saturating error counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                addr_q <= cmd_addr & ~ALIGN_MASK;
                if (cmd_write) wdata_q <= cmd_wdata;
            end
            if (b_cap) begin
                rsp_write_q <= 1'b1;
                rsp_rdata_q <= '0;
                rsp_resp_q  <= m_axi.bresp;
            end
            if (r_cap) begin
                rsp_write_q <= 1'b0;
                rsp_rdata_q <= m_axi.rdata;
                rsp_resp_q  <= m_axi.rresp;
            end
            if ((b_cap || r_cap) && axi_resp_t'(cap_resp) != OKAY && err_cnt_q != '1)
                err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_axi4_lite_mgr.sv
// Bench for axi4_lite_mgr: directed scenarios plus random writes/reads against
// a stub subordinate, checked against an address-indexed reference memory.
module tb_axi4_lite_mgr;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] err_count;

    axi4_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) axi ();

    axi4_lite_mgr #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .err_count (err_count),
        .m_axi     (axi)
    );

    always #5 aclk = ~aclk;

    // Stub subordinate: ready knobs for AW/W, B response gate, 64-word memory,
    // SLVERR for address 0x10 on both reads and writes.
    logic        awready_en = 1'b1;
    logic        wready_en  = 1'b1;
    logic        b_en       = 1'b1;
    logic        got_aw, got_w;
    logic [31:0] sub_awaddr, sub_wdata;
    logic [31:0] sub_mem [0:63];

    assign axi.awready = awready_en;
    assign axi.wready  = wready_en;
    assign axi.arready = 1'b1;

    wire        s_aw_hs  = axi.awvalid && axi.awready;
    wire        s_w_hs   = axi.wvalid && axi.wready;
    wire        have_aw  = got_aw || s_aw_hs;
    wire        have_w   = got_w || s_w_hs;
    wire [31:0] aw_eff   = s_aw_hs ? axi.awaddr : sub_awaddr;
    wire [31:0] w_eff    = s_w_hs ? axi.wdata : sub_wdata;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            got_aw     <= 1'b0;
            got_w      <= 1'b0;
            sub_awaddr <= '0;
            sub_wdata  <= '0;
            axi.bvalid <= 1'b0;
            axi.bresp  <= 2'b00;
            axi.rvalid <= 1'b0;
            axi.rdata  <= '0;
            axi.rresp  <= 2'b00;
            for (int i = 0; i < 64; i++) sub_mem[i] <= '0;
        end else begin
            if (s_aw_hs) begin got_aw <= 1'b1; sub_awaddr <= axi.awaddr; end
            if (s_w_hs)  begin got_w  <= 1'b1; sub_wdata  <= axi.wdata;  end
            if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
            if (have_aw && have_w && b_en && !axi.bvalid) begin
                axi.bvalid <= 1'b1;
                axi.bresp  <= (aw_eff == 32'h10) ? 2'b10 : 2'b00;
                sub_mem[aw_eff[7:2]] <= w_eff;
                got_aw <= 1'b0;
                got_w  <= 1'b0;
            end
            if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
            if (axi.arvalid && axi.arready) begin
                axi.rvalid <= 1'b1;
                axi.rdata  <= sub_mem[axi.araddr[7:2]];
                axi.rresp  <= (axi.araddr == 32'h10) ? 2'b10 : 2'b00;
            end
        end
    end

    // Reference model: what the subordinate should hold and how many errors.
    logic [31:0] ref_mem [int];
    logic [15:0] exp_err = '0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command through the manager with a fast subordinate; `hold` cycles
    // of response backpressure before rsp_ready is raised.
    task automatic do_cmd(input bit w, input logic [31:0] a, input logic [31:0] d, input int hold);
        logic [31:0] al, exp_rd, held;
        logic [1:0]  exp_resp;
        int          lat;
        al       = a & ~32'h3;
        exp_resp = (al == 32'h10) ? 2'b10 : 2'b00;
        if (w) begin
            ref_mem[al] = d;
            exp_rd = '0;
        end else begin
            exp_rd = ref_mem.exists(al) ? ref_mem[al] : 32'h0;
        end
        if (exp_resp != 2'b00 && exp_err != 16'hFFFF) exp_err++;

        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        rsp_ready = (hold == 0);
        lat = 0;
        while (!cmd_ready && lat < 50) begin @(negedge aclk); lat++; end
        chk(cmd_ready, 1, "cmd_ready_idle");
        @(negedge aclk);
        cmd_valid = 1'b0;
        chk(cmd_ready, 0, "cmd_ready_busy");
        if (w) begin
            chk({axi.awvalid, axi.wvalid}, 2'b11, "aw_w_valid");
            chk(axi.awaddr, al, "awaddr");
            chk(axi.wdata, d, "wdata");
        end else begin
            chk(axi.arvalid, 1, "arvalid");
            chk(axi.araddr, al, "araddr");
        end
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge aclk); lat++; end
        chk(rsp_valid, 1, "rsp_valid");
        chk(lat, 3, "latency");
        chk(rsp_write, w, "rsp_write");
        chk(rsp_rdata, exp_rd, "rsp_rdata");
        chk(rsp_resp, exp_resp, "rsp_resp");
        chk(err_count, exp_err, "err_count");
        held = rsp_rdata;
        for (int k = 0; k < hold; k++) begin
            @(negedge aclk);
            chk(rsp_valid, 1, "bp_rsp_valid");
            chk(rsp_rdata, held, "bp_rsp_rdata");
            chk(cmd_ready, 0, "bp_cmd_ready");
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        chk(rsp_valid, 0, "rsp_done");
        chk(cmd_ready, 1, "back_to_idle");
    endtask

    initial begin
        int n_rsp;
        logic [31:0] ra, rd;

        // Reset values
        repeat (3) @(negedge aclk);
        chk(cmd_ready, 1, "rst_cmd_ready");
        chk(rsp_valid, 0, "rst_rsp_valid");
        chk({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 5'b0, "rst_axi_ctl");
        chk(axi.awaddr, 0, "rst_awaddr");
        chk(axi.araddr, 0, "rst_araddr");
        chk(axi.wdata, 0, "rst_wdata");
        chk({rsp_write, rsp_rdata, rsp_resp}, 0, "rst_rsp_payload");
        chk(err_count, 0, "rst_err_count");
        aresetn = 1'b1;

        // Write then read back
        do_cmd(1'b1, 32'h0, 32'hDEADBEEF, 0);
        do_cmd(1'b0, 32'h0, 32'h0, 0);

        // Error responses: 1 then 4
        do_cmd(1'b0, 32'h10, 32'h0, 0);
        chk(err_count, 1, "err_once");
        repeat (3) do_cmd(1'b0, 32'h10, 32'h0, 0);
        chk(err_count, 4, "err_four");

        // Response backpressure on read of 0x04
        do_cmd(1'b1, 32'h4, 32'h12345678, 0);
        do_cmd(1'b0, 32'h4, 32'h0, 5);

        // Misaligned read
        do_cmd(1'b0, 32'h6, 32'h0, 0);

        // Split handshake: W completes at once, AW stalls three cycles
        awready_en = 1'b0;
        ref_mem[32'h20] = 32'hA5A5_0F0F;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hA5A5_0F0F;
        rsp_ready = 1'b1;
        @(negedge aclk);
        cmd_valid = 1'b0;
        chk({axi.awvalid, axi.wvalid}, 2'b11, "split_c1_valid");
        for (int k = 2; k <= 4; k++) begin
            @(negedge aclk);
            chk({axi.awvalid, axi.wvalid}, 2'b10, "split_aw_held");
            chk(axi.awaddr, 32'h20, "split_awaddr");
        end
        awready_en = 1'b1;
        n_rsp = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            if (rsp_valid) n_rsp++;
        end
        chk(n_rsp, 1, "split_one_rsp");
        do_cmd(1'b0, 32'h20, 32'h0, 0);

        // Random traffic
        for (int i = 0; i < 24; i++) begin
            ra = $urandom_range(0, 255);
            rd = $urandom;
            do_cmd(1'($urandom_range(0, 1)), ra, rd, (i % 5 == 0) ? 2 : 0);
        end

        // Reset while waiting in WR_RESP
        b_en = 1'b0;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'h1111_1111;
        rsp_ready = 1'b1;
        @(negedge aclk);
        cmd_valid = 1'b0;
        @(negedge aclk);
        chk({axi.bready, axi.awvalid, axi.wvalid}, 3'b100, "wr_resp_state");
        #2 aresetn = 1'b0;
        #1;
        chk({axi.bready, axi.awvalid, axi.wvalid}, 3'b000, "async_rst_axi");
        chk(rsp_valid, 0, "async_rst_rsp");
        chk(err_count, 0, "async_rst_err");
        @(negedge aclk);
        aresetn = 1'b1;
        b_en = 1'b1;
        ref_mem.delete();
        exp_err = '0;
        @(negedge aclk);
        chk(cmd_ready, 1, "post_rst_ready");
        chk(rsp_valid, 0, "post_rst_no_rsp");
        do_cmd(1'b1, 32'h0, 32'hBEBEBABA, 0);
        do_cmd(1'b0, 32'h0, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
